// File: rtl/pwm_pkg.sv
// Shared types and helpers for the counter-driven PWM channel.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } pwm_state_t;

  // Duty needs one extra bit so a full-period (always high) duty is representable.
  function automatic int duty_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/cnt_wrap_detect.sv
// Flags the cycle where a shared free-running counter rolls over from max to 0.
module cnt_wrap_detect #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CNT_WIDTH-1:0] counter,
  output logic                 wrap
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] prev_cnt_q;
  logic [CNT_WIDTH-1:0] prev_cnt_d;

  always_comb prev_cnt_d = counter;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_cnt_q <= '0;
    else          prev_cnt_q <= prev_cnt_d;
  end

  // A counter parked at 0 never looks like a wrap because prev must be max.
  assign wrap = (counter == '0) && (prev_cnt_q == CNT_MAX);

endmodule

// File: rtl/counter_nbit.sv
// Free-running N-bit counter shared by PWM channels; en=0 holds the count.
module counter_nbit #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pwm_from_counter.sv
// PWM channel slaved to a shared counter; duty changes are applied only at counter wrap.
// Handshake: a duty value transfers on a cycle where duty_valid && duty_ready at the clock edge.
module pwm_from_counter
  import pwm_pkg::*;
#(
  parameter  int CNT_WIDTH = 3,
  localparam int DUTY_W    = duty_w(CNT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CNT_WIDTH-1:0] counter,
  input  logic                 enable,
  input  logic [DUTY_W-1:0]    duty_in,
  input  logic                 duty_valid,
  output logic                 duty_ready,
  output logic                 pwm_out,
  output logic                 period_tick,
  output logic                 running,
  output pwm_state_t           dbg_state
);

  localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(2 ** CNT_WIDTH);

  logic wrap;

  cnt_wrap_detect #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_wrap (
    .clk     (clk),
    .reset_n (reset_n),
    .counter (counter),
    .wrap    (wrap)
  );

  logic [DUTY_W-1:0] pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [DUTY_W-1:0] act_q, act_d;
  logic [DUTY_W-1:0] eff;
  logic              accept;
  logic              apply;

  assign duty_ready = !pend_v_q;
  assign accept     = duty_valid && duty_ready;
  assign apply      = wrap && pend_v_q;
  assign eff        = apply ? pend_q : act_q;

  // apply and accept are exclusive: accept needs pend_v_q low, apply needs it high.
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    act_d    = act_q;
    if (apply) begin
      act_d    = pend_q;
      pend_v_d = 1'b0;
    end
    if (accept) begin
      pend_d   = (duty_in > DUTY_FULL) ? DUTY_FULL : duty_in;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      act_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      act_q    <= act_d;
    end
  end

  pwm_state_t state_q, state_d;
  logic       pwm_q, pwm_d;
  logic       tick_q, tick_d;
  logic       run_q, run_d;
  logic       live_next;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (enable) state_d = ARMED;
      ARMED: begin
        if (wrap)         state_d = RUN;
        else if (!enable) state_d = IDLE;
      end
      RUN:   if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)    state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the next state so the first RUN period begins on the wrap itself.
  always_comb begin
    live_next = (state_d == RUN) || (state_d == DRAIN);
    pwm_d     = live_next && ({1'b0, counter} < eff);
    tick_d    = wrap && ((state_q == RUN) || (state_q == DRAIN));
    run_d     = live_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pwm_q   <= 1'b0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
      tick_q  <= tick_d;
      run_q   <= run_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;
  assign running     = run_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pwm_from_counter.sv
// Directed bench for pwm_from_counter fed by counter_nbit, with a period-level reference model.
module tb_pwm_from_counter;

  logic       clk;
  logic       reset_n;
  logic       cnt_en;
  logic [2:0] counter;
  logic       enable;
  logic [3:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic       period_tick;
  logic       running;
  pwm_pkg::pwm_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  counter_nbit #(.WIDTH(3)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cnt_en),
    .count   (counter)
  );

  pwm_from_counter #(.CNT_WIDTH(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .counter     (counter),
    .enable      (enable),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .running     (running),
    .dbg_state   (dbg_state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the channel is either producing whole periods (live) or not;
  // it starts producing at the first wrap after being armed and stops at a wrap
  // once enable has been low for more than one cycle.
  bit         m_live, m_armed, m_en_last;
  int         m_act, m_prev;
  int         pend_m[$];
  logic [3:0] exp_q[$];
  logic [3:0] got, exp_v;
  bit         m_wrap, m_rdy, m_tick, m_pwm;

  always @(negedge clk) begin
    got = {pwm_out, period_tick, running, duty_ready};
    if (!reset_n) begin
      m_live = 0; m_armed = 0; m_en_last = 0; m_act = 0; m_prev = 0;
      pend_m.delete();
      exp_q.delete();
      check("reset_outputs", got, 4'b0001);
      exp_q.push_back(4'b0001);
    end else begin
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        check("cycle_outputs", got, exp_v);
      end
      m_wrap = (counter == 0) && (m_prev == 7);
      m_rdy  = (pend_m.size() == 0);
      m_tick = m_wrap && m_live;
      if (m_wrap && !m_rdy) m_act = pend_m.pop_front();
      if (duty_valid && m_rdy) pend_m.push_back((duty_in > 8) ? 8 : int'(duty_in));
      if (!m_live) begin
        if (!m_armed)     m_armed = enable;
        else if (m_wrap)  begin m_live = 1; m_armed = 0; end
        else if (!enable) m_armed = 0;
      end else if (!enable && !m_en_last && m_wrap) begin
        m_live = 0;
      end
      m_pwm = m_live && (int'(counter) < m_act);
      exp_q.push_back({m_pwm, m_tick, m_live, pend_m.size() == 0});
      m_prev    = int'(counter);
      m_en_last = enable;
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cnt(input int v);
    int b = 0;
    while (int'(counter) != v && b < 64) begin
      step_cycles(1);
      b++;
    end
    check("wait_cnt", 32'(counter), 32'(v));
  endtask

  task automatic write_duty(input int d);
    int b = 0;
    duty_in    = 4'(d);
    duty_valid = 1'b1;
    while (!duty_ready && b < 64) begin
      step_cycles(1);
      b++;
    end
    check("duty_accept_ready", 32'(duty_ready), 1);
    step_cycles(1);
    duty_valid = 1'b0;
  endtask

  task automatic observe(input int n, output int hi, output int tk, output int rn);
    hi = 0; tk = 0; rn = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(pwm_out);
      tk += int'(period_tick);
      rn += int'(running);
    end
    @(posedge clk);
    #1;
  endtask

  int hi, tk, rn;

  initial begin
    reset_n    = 1'b0;
    cnt_en     = 1'b1;
    enable     = 1'b0;
    duty_in    = 4'd0;
    duty_valid = 1'b0;
    step_cycles(3);
    check("rst_pwm_out", 32'(pwm_out), 0);
    check("rst_period_tick", 32'(period_tick), 0);
    check("rst_running", 32'(running), 0);
    check("rst_duty_ready", 32'(duty_ready), 1);
    reset_n = 1'b1;
    step_cycles(2);

    // basic run with duty 3
    write_duty(3);
    enable = 1'b1;
    step_cycles(20);
    wait_cnt(0);
    observe(8, hi, tk, rn);
    check("basic_high_count", 32'(hi), 3);
    check("basic_tick_count", 32'(tk), 1);

    // duty extremes, including clamp of 9
    write_duty(0);
    step_cycles(10);
    wait_cnt(0);
    observe(8, hi, tk, rn);
    check("duty0_high", 32'(hi), 0);
    check("duty0_tick", 32'(tk), 1);
    write_duty(8);
    step_cycles(10);
    wait_cnt(0);
    observe(8, hi, tk, rn);
    check("duty8_high", 32'(hi), 8);
    check("duty8_tick", 32'(tk), 1);
    write_duty(9);
    step_cycles(10);
    wait_cnt(0);
    observe(8, hi, tk, rn);
    check("duty9_clamped_high", 32'(hi), 8);
    check("duty9_tick", 32'(tk), 1);

    // mid-period update: 6 written at counter 4 while 3 is active
    write_duty(3);
    step_cycles(10);
    wait_cnt(0);
    wait_cnt(4);
    duty_in    = 4'd6;
    duty_valid = 1'b1;
    step_cycles(1);
    duty_in = 4'd2;
    check("mid_ready_low_c5", 32'(duty_ready), 0);
    step_cycles(1);
    check("mid_ready_low_c6", 32'(duty_ready), 0);
    step_cycles(1);
    check("mid_ready_low_c7", 32'(duty_ready), 0);
    duty_valid = 1'b0;
    wait_cnt(0);
    observe(8, hi, tk, rn);
    check("mid_next_period_high", 32'(hi), 6);

    // drain: enable dropped at counter 2 finishes the period then idles
    wait_cnt(2);
    enable = 1'b0;
    observe(12, hi, tk, rn);
    check("drain_final_tick", 32'(tk), 1);
    step_cycles(8);
    check("drain_idle_running", 32'(running), 0);
    check("drain_idle_pwm", 32'(pwm_out), 0);

    // re-enable inside DRAIN keeps running without a gap
    enable = 1'b1;
    step_cycles(20);
    wait_cnt(2);
    enable = 1'b0;
    wait_cnt(5);
    enable = 1'b1;
    observe(16, hi, tk, rn);
    check("redrain_running_cycles", 32'(rn), 16);
    check("redrain_high_cycles", 32'(hi), 12);

    // asynchronous reset mid-run with duty 8 (output high)
    write_duty(8);
    step_cycles(10);
    wait_cnt(0);
    step_cycles(2);
    check("pre_reset_pwm", 32'(pwm_out), 1);
    check("pre_reset_running", 32'(running), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_pwm", 32'(pwm_out), 0);
    check("async_reset_running", 32'(running), 0);
    cnt_en = 1'b0;
    step_cycles(2);
    reset_n = 1'b1;

    // counter parked at 0: no wrap, stays armed, duty stays pending
    write_duty(5);
    step_cycles(20);
    check("held_running", 32'(running), 0);
    check("held_duty_pending", 32'(duty_ready), 0);
    check("held_state_armed", 32'(dbg_state), 32'(pwm_pkg::ARMED));
    cnt_en = 1'b1;
    step_cycles(12);
    check("released_running", 32'(running), 1);
    wait_cnt(0);
    observe(8, hi, tk, rn);
    check("released_high", 32'(hi), 5);

    enable = 1'b0;
    step_cycles(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_from_counter.md
# pwm_from_counter

Downstream consumer of the free-running `counter_nbit` value. It turns the shared counter into a glitch-free PWM output. Duty updates arrive over a valid/ready handshake and take effect only at a counter wrap, so every period is complete and uses a single duty value. Several instances can share one `counter_nbit`, giving phase-aligned PWM channels.

## Interface
- `CNT_WIDTH`, 3: width of the incoming counter; the period is 2^CNT_WIDTH cycles.
- `DUTY_W`, derived as CNT_WIDTH+1 (localparam, not overridable): duty width, range 0..2^CNT_WIDTH.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `counter`  in  CNT_WIDTH  free-running count from `counter_nbit`, same clock.
- `enable`  in  1  request to run PWM.
- `duty_in`  in  DUTY_W  new duty, in counts of high time per period.
- `duty_valid`  in  1  `duty_in` is offered.
- `duty_ready`  out  1  block can accept a duty value.
- `pwm_out`  out  1  registered PWM output.
- `period_tick`  out  1  one-cycle pulse per completed running period.
- `running`  out  1  high in RUN or DRAIN.

## Operation
- Wrap detect: `prev_cnt` register, reset 0. `wrap = (counter == 0) && (prev_cnt == 2^CNT_WIDTH-1)`.
- Duty path: a pending register `pend` plus flag `pend_v`, and an active register `act`.
  - `duty_ready = !pend_v`.
  - Accept on `duty_valid && duty_ready`: `pend <= min(duty_in, 2^CNT_WIDTH)`, `pend_v <= 1`.
  - On `wrap` with `pend_v`: `act <= pend`, `pend_v <= 0`.
  - An accept in a wrap cycle lands in `pend` and is applied at the following wrap, not the current one.
- Effective duty: `eff = (wrap && pend_v) ? pend : act`.
- Duty 0 gives a constant low output; duty 2^CNT_WIDTH gives a constant high output.
- FSM states: IDLE, ARMED, RUN, DRAIN.
  - IDLE: `enable` goes to ARMED.
  - ARMED: `wrap` goes to RUN; `!enable` goes to IDLE.
  - RUN: `!enable` goes to DRAIN.
  - DRAIN: `enable` goes back to RUN; otherwise `wrap` goes to IDLE.
  - Outputs are evaluated on next-state, so the RUN period starts at the wrap cycle. The DRAIN→IDLE wrap produces a low output.
- `pwm_out <= (next_state == RUN || next_state == DRAIN) && (counter < eff)`. The comparison is unsigned, with `counter` zero-extended to DUTY_W.
- `period_tick <= wrap && (state == RUN || state == DRAIN)`.
- `running <= next_state == RUN || next_state == DRAIN`.

## Timing
- Reset values:
  - Outputs: `pwm_out` 0, `period_tick` 0, `running` 0, `duty_ready` 1.
  - Internal: `act` 0, `pend_v` 0, `prev_cnt` 0, state IDLE.
- Reset mid-operation clears everything asynchronously. The pending duty is lost.
- `pwm_out` lags `counter` by exactly 1 cycle. The high time per period equals `act`, with no partial periods.
- `duty_ready` drops the cycle after an accept and rises the cycle after the applying wrap.
- `period_tick` asserts 1 cycle after each wrap, every 2^CNT_WIDTH cycles while running. It also fires for the final DRAIN period.
- `enable` high to the first `pwm_out` high takes at most 2^CNT_WIDTH+1 cycles.
- If the counter is held at 0 (upstream in reset), no wrap occurs: the FSM stays ARMED and the duty stays pending.

## Structure
- Shared package `pwm_pkg` holds:
  - the state enum `pwm_state_t` (IDLE, ARMED, RUN, DRAIN);
  - the DUTY_W helper function.
- One sub-module: `cnt_wrap_detect`, parameterised by CNT_WIDTH. It contains the `prev_cnt` register and the `wrap` output, and is reusable by other consumers of `counter_nbit`.

## Test plan
All scenarios use CNT_WIDTH=3, with `counter_nbit` instantiated as the source.
- **Reset:** hold `reset_n`=0 for 3 cycles → all outputs 0, `duty_ready`=1. Then assert reset mid-RUN → `pwm_out`/`running` drop without waiting for a clock edge.
- **Basic run:** write duty 3, then `enable`=1 → after the first wrap, `pwm_out` is high 3 cycles / low 5 cycles per 8-cycle period, and `period_tick` pulses every 8 cycles.
- **Duty extremes:** duty 0 → `pwm_out` constant 0. Duty 8 → constant 1. Duty 9 → clamped, constant 1. `period_tick` keeps pulsing in all three cases.
- **Mid-period update:** active duty 3; write 6 while `counter`=4 → rest of the current period uses 3, the next uses 6. `duty_ready` stays 0 until the wrap, and a second `duty_valid` during that time is held off.
- **Drain:** drop `enable` at `counter`=2 → the period completes, `period_tick` fires, then IDLE with `pwm_out`=0. A separate run re-raises `enable` at `counter`=5 during DRAIN → stays RUN with no gap in the output.
